// File: rtl/writeback_buffer_if.sv
// writeback_buffer_if: execution-channel, flush and register-file write bundle
interface writeback_buffer_if #(
    parameter int des = 4,
    parameter int register_width = 8,
    parameter int branch_id = 3
);
    logic flush_vld;
    logic [branch_id-1:0] flush_bid;
    logic [3:0] ex_vld;
    logic [3:0][des-1:0] ex_des;
    logic [3:0][register_width-1:0] ex_data;
    logic [3:0][branch_id-1:0] ex_bid;
    logic [3:0] ex_rdy;
    logic [3:0] back_vld;
    logic [3:0][des-1:0] back_des;
    logic [3:0][register_width-1:0] back_data;
    logic wb_busy;
    modport master (
        output flush_vld, flush_bid, ex_vld, ex_des, ex_data, ex_bid,
        input ex_rdy, back_vld, back_des, back_data, wb_busy
    );
    modport slave (
        input flush_vld, flush_bid, ex_vld, ex_des, ex_data, ex_bid,
        output ex_rdy, back_vld, back_des, back_data, wb_busy
    );
endinterface

// File: rtl/writeback_buffer.sv
// writeback_buffer: per-channel FIFOs feeding registered register-file write ports
module writeback_buffer #(
    parameter int des = 4,
    parameter int register_width = 8,
    parameter int branch_id = 3,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    writeback_buffer_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);
    logic [des-1:0] ent_des_q [4][FIFO_DEPTH], ent_des_d [4][FIFO_DEPTH];
    logic [register_width-1:0] ent_data_q [4][FIFO_DEPTH], ent_data_d [4][FIFO_DEPTH];
    logic [branch_id-1:0] ent_bid_q [4][FIFO_DEPTH], ent_bid_d [4][FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] live_q [4], live_d [4];
    logic [PW-1:0] wr_ptr_q [4], wr_ptr_d [4], rd_ptr_q [4], rd_ptr_d [4];
    logic [PW:0] cnt_q [4], cnt_d [4];
    logic [3:0] back_vld_q, back_vld_d;
    logic [3:0][des-1:0] back_des_q, back_des_d;
    logic [3:0][register_width-1:0] back_data_q, back_data_d;
    logic wb_busy_q, wb_busy_d;
    logic [3:0] writable, stall, push, pop, rdy;
    logic [des-1:0] h_des [4];
    logic [register_width-1:0] h_data [4];
    always_comb begin
        ent_des_d = ent_des_q;
        ent_data_d = ent_data_q;
        ent_bid_d = ent_bid_q;
        live_d = live_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d = cnt_q;
        back_vld_d = '0;
        back_des_d = back_des_q;
        back_data_d = back_data_q;
        wb_busy_d = 1'b0;
        writable = '0;
        stall = '0;
        push = '0;
        pop = '0;
        rdy = '0;
        for (int c = 0; c < 4; c++) begin
            h_des[c] = ent_des_q[c][rd_ptr_q[c]];
            h_data[c] = ent_data_q[c][rd_ptr_q[c]];
            writable[c] = cnt_q[c] != '0 && live_q[c][rd_ptr_q[c]] && h_des[c] != '0 &&
                          !(bus.flush_vld && ent_bid_q[c][rd_ptr_q[c]] == bus.flush_bid);
            // lower channels win a same-destination conflict
            for (int i = 0; i < c; i++)
                stall[c] = stall[c] | (writable[i] && h_des[i] == h_des[c]);
            rdy[c] = cnt_q[c] != FULL;
            push[c] = bus.ex_vld[c] && rdy[c];
            pop[c] = cnt_q[c] != '0 && !(writable[c] && stall[c]);
            if (bus.flush_vld)
                for (int e = 0; e < FIFO_DEPTH; e++)
                    if (ent_bid_q[c][e] == bus.flush_bid) live_d[c][e] = 1'b0;
            if (push[c]) begin
                ent_des_d[c][wr_ptr_q[c]] = bus.ex_des[c];
                ent_data_d[c][wr_ptr_q[c]] = bus.ex_data[c];
                ent_bid_d[c][wr_ptr_q[c]] = bus.ex_bid[c];
                live_d[c][wr_ptr_q[c]] = !(bus.flush_vld && bus.ex_bid[c] == bus.flush_bid);
                wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
            end
            if (pop[c]) rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
            cnt_d[c] = cnt_q[c] + (PW + 1)'(push[c]) - (PW + 1)'(pop[c]);
            if (writable[c] && !stall[c]) begin
                back_vld_d[c] = 1'b1;
                back_des_d[c] = h_des[c];
                back_data_d[c] = h_data[c];
            end
            wb_busy_d = wb_busy_d | (cnt_d[c] != '0);
        end
    end
    always_ff @(posedge clk) begin
        ent_des_q <= ent_des_d;
        ent_data_q <= ent_data_d;
        ent_bid_q <= ent_bid_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q <= '{default: '0};
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            cnt_q <= '{default: '0};
            back_vld_q <= '0;
            back_des_q <= '0;
            back_data_q <= '0;
            wb_busy_q <= 1'b0;
        end else begin
            live_q <= live_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
            back_vld_q <= back_vld_d;
            back_des_q <= back_des_d;
            back_data_q <= back_data_d;
            wb_busy_q <= wb_busy_d;
        end
    end
    assign bus.ex_rdy = rdy;
    assign bus.back_vld = back_vld_q;
    assign bus.back_des = back_des_q;
    assign bus.back_data = back_data_q;
    assign bus.wb_busy = wb_busy_q;
endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: directed vectors with hand-computed expectations
module tb_writeback_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int nxt, exp_v, nw, stale;
    logic acc;
    writeback_buffer_if bus ();
    writeback_buffer dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.ex_vld = '0;
        bus.flush_vld = 1'b0;
        bus.flush_bid = '0;
    endtask
    task automatic drive(input int c, input logic [3:0] d, input logic [7:0] v, input logic [2:0] b);
        bus.ex_vld[c] = 1'b1;
        bus.ex_des[c] = d;
        bus.ex_data[c] = v;
        bus.ex_bid[c] = b;
    endtask
    initial begin
        bus.ex_des = '0;
        bus.ex_data = '0;
        bus.ex_bid = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        check("rst_vld", bus.back_vld, 0);
        check("rst_rdy", bus.ex_rdy, 4'hF);
        check("rst_busy", bus.wb_busy, 0);
        check("rst_des", bus.back_des, 0);
        // single result, two-cycle latency
        drive(0, 5, 8'h3C, 2);
        tick();
        idle();
        check("single_busy_hi", bus.wb_busy, 1);
        check("single_early", bus.back_vld, 0);
        tick();
        check("single_vld", bus.back_vld, 4'b0001);
        check("single_des", bus.back_des[0], 5);
        check("single_data", bus.back_data[0], 8'h3C);
        check("single_busy_lo", bus.wb_busy, 0);
        tick();
        check("single_after", bus.back_vld, 0);
        // same-destination conflict between channels 1 and 3
        drive(0, 7, 8'hAA, 0);
        drive(1, 9, 8'h55, 0);
        drive(2, 7, 8'hBB, 0);
        tick();
        idle();
        tick();
        check("conf_t_vld", bus.back_vld, 4'b0011);
        check("conf_t_d1", bus.back_data[0], 8'hAA);
        check("conf_t_d2", bus.back_data[1], 8'h55);
        check("conf_t_des2", bus.back_des[1], 9);
        tick();
        check("conf_t1_vld", bus.back_vld, 4'b0100);
        check("conf_t1_d3", bus.back_data[2], 8'hBB);
        tick();
        check("conf_done", bus.back_vld, 0);
        // backpressure: channel 1 keeps des=3 busy so channel 2 fills and wraps
        nxt = 1;
        exp_v = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            idle();
            if (cyc < 8) drive(0, 3, 8'(8'h10 + cyc), 0);
            if (nxt <= 6) drive(1, 3, 8'(nxt), 0);
            acc = bus.ex_vld[1] && bus.ex_rdy[1];
            tick();
            if (acc) nxt++;
            if (bus.back_vld[1]) begin
                check("bp_data", bus.back_data[1], exp_v);
                exp_v++;
            end
            if (cyc == 3 || cyc == 7) check("bp_rdy_full", bus.ex_rdy[1], 0);
        end
        idle();
        check("bp_count", exp_v, 7);
        check("bp_busy", bus.wb_busy, 0);
        // flush bid 1 on channel 4 while blocked behind channel 1
        nw = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            idle();
            if (cyc < 6) drive(0, 6, 8'h20, 0);
            if (cyc == 0) drive(3, 6, 8'h41, 1);
            else if (cyc == 1) drive(3, 6, 8'h43, 3);
            else if (cyc == 2) drive(3, 6, 8'h45, 1);
            else if (cyc == 3) begin
                drive(3, 6, 8'h47, 1);
                bus.flush_vld = 1'b1;
                bus.flush_bid = 3'd1;
            end
            tick();
            if (bus.back_vld[3]) begin
                nw++;
                check("flush_data", bus.back_data[3], 8'h43);
            end
        end
        idle();
        check("flush_writes", nw, 1);
        check("flush_busy", bus.wb_busy, 0);
        // zero destination dropped, following result still written
        drive(0, 0, 8'hFF, 0);
        tick();
        check("zero_e0", bus.back_vld, 0);
        idle();
        drive(0, 4, 8'h44, 0);
        tick();
        idle();
        check("zero_drop", bus.back_vld, 0);
        tick();
        check("zero_next_vld", bus.back_vld, 4'b0001);
        check("zero_next_des", bus.back_des[0], 4);
        check("zero_next_data", bus.back_data[0], 8'h44);
        tick();
        check("zero_busy", bus.wb_busy, 0);
        // reset mid-burst discards everything buffered
        for (int cyc = 0; cyc < 3; cyc++) begin
            idle();
            for (int c = 0; c < 4; c++) drive(c, 8, 8'(16 * c + cyc + 1), 0);
            tick();
        end
        idle();
        check("mid_busy_pre", bus.wb_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_vld", bus.back_vld, 0);
        check("mid_rdy", bus.ex_rdy, 4'hF);
        check("mid_busy", bus.wb_busy, 0);
        check("mid_data", bus.back_data, 0);
        stale = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (bus.back_vld != 4'b0000 || bus.wb_busy) stale++;
        end
        check("mid_stale", stale, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Collects results from the four execution channels and drives the register-file write ports (back_1..back_4 vld/des/data).
- Each channel has a small FIFO that absorbs bursts and backpressures its execution unit through a ready signal.
- Resolves same-destination conflicts between channels in a single cycle.
- Squashes results belonging to a mispredicted branch before they are written.

Parameters:
- des, 4, destination register index width
- register_width, 8, data width
- branch_id, 3, branch tag width
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_vld  in  1  branch mispredict flush strobe
- flush_bid  in  branch_id  tag of the mispredicted branch
- ex_N_vld  in  1  result valid from execution channel N (N=1..4)
- ex_N_des  in  des  destination register of the result on channel N
- ex_N_data  in  register_width  result data on channel N
- ex_N_bid  in  branch_id  branch tag of the result on channel N
- ex_N_rdy  out  1  channel N FIFO can accept a result this cycle
- back_N_vld  out  1  register-file write enable, port N
- back_N_des  out  des  register-file write index, port N
- back_N_data  out  register_width  register-file write data, port N
- wb_busy  out  1  at least one FIFO entry is occupied

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all FIFOs emptied and every entry's live bit cleared. back_N_vld=0, back_N_des=0, back_N_data=0, wb_busy=0, ex_N_rdy=1 in the cycle after reset. Reset asserted mid-operation discards all buffered results, and no back_N_vld is driven during or after it until a new result arrives.
- Enqueue: on a posedge with ex_N_vld && ex_N_rdy, push {des, data, bid, live=1} into FIFO N. If ex_N_vld is high while ex_N_rdy=0, nothing is pushed and the producer must hold.
- Ready: ex_N_rdy = (count_N < FIFO_DEPTH), computed from registered count only. A same-cycle pop does not raise rdy.
- Head candidates: each non-empty FIFO presents its head every cycle. A head is "writable" if live=1, des≠0, and it is not flush-matched this cycle.
- Conflict rule: head j stalls (no pop) if any writable head i<j has the same des. Lower channel index drains first; j drains in a later cycle.
- Pop: a head pops if it is non-writable (dead or des==0; dropped silently) or writable and not stalled. At most one pop per FIFO per cycle. Simultaneous push and pop on a full FIFO is not possible, because rdy=0 when full.
- Output register: back_N_* are registered.
  - back_N_vld <= (head N writable && not stalled). back_N_des and back_N_data load the head fields.
  - When back_N_vld <= 0, des/data hold their previous values.
  - Output port N always carries channel N; no cross-channel routing.
- Latency: a result accepted at edge E0 appears on back_N_* after edge E1, i.e. 2 cycles from ex_N_vld to back_N_vld when its FIFO was empty and there is no conflict.
- Throughput: 1 result per channel per cycle.
- Flush: on a cycle with flush_vld:
  - Every stored entry with bid==flush_bid gets live=0.
  - An entry enqueued in the same cycle with matching bid is stored with live=0.
  - A head matching flush_bid in that cycle is not written; it pops silently.
  - Values already registered on back_N_* are not recalled.
  - Entries with a different bid are unaffected.
- Dead and zero-destination entries still occupy FIFO slots until they reach the head. Each pops in one cycle with back_N_vld=0.
- FIFO pointers: log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH. count_N is log2(FIFO_DEPTH)+1 bits.
- wb_busy: registered OR of (count_N≠0) over all channels.

Test Plan:
- Single result: after reset, ex_1 {des=5, data=0x3C, bid=2} for 1 cycle -> back_1_vld=1, des=5, data=0x3C exactly 2 cycles later; all other back_N_vld=0; wb_busy 1 then 0.
- Backpressure and wrap: drive ex_2 with 6 consecutive results (data 1..6) while conflicting head on channel 1 des=same blocks draining -> ex_2_rdy=0 after 4 accepted. Release -> data 1..6 emerge on back_2 in order, none lost or duplicated; pointers wrap cleanly.
- Conflict: ex_1 and ex_3 both des=7 (data 0xAA, 0xBB) same cycle -> back_1 writes 0xAA in cycle T; back_3 writes 0xBB in T+1. ex_2 with des=9 in the same cycle writes at T, unaffected.
- Flush: buffer channel 4 with bids 1, 3, 1, and assert flush_vld with flush_bid=1 while a new bid=1 result is accepted -> only the bid=3 result is written; dead entries drain with back_4_vld=0.
- Zero destination: ex_1 des=0 data=0xFF -> back_1_vld never asserted; FIFO empties; a following des=4 result still meets the 2-cycle latency if enqueued behind it, plus 1 cycle for the drop.
- Reset mid-burst: with 3 entries buffered on each channel, pulse rst for 1 cycle -> next cycle all back_N_vld=0, ex_N_rdy=1, wb_busy=0; no stale results ever emerge.
